// File: rtl/otter_pkg.sv
// Shared load-path types: ld_size encoding, load FSM states and the
// alignment legality rule used when a load request is accepted.
package otter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } ld_size_e;

  typedef enum logic [1:0] {
    LD_IDLE = 2'b00,
    LD_BUSY = 2'b01,
    LD_DONE = 2'b10
  } ld_state_e;

  // Byte loads are always legal; half needs addr[0]==0, word needs addr[1:0]==0.
  function automatic logic ld_legal(input ld_size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: ld_legal = 1'b1;
      SZ_HALF: ld_legal = ~off[0];
      SZ_WORD: ld_legal = (off == 2'b00);
      default: ld_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a memory word.
module load_align
  import otter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/half lane, then extend per size and signedness.
  always_comb begin
    case (addr_lo)
      2'b00:   lane_b = word[7:0];
      2'b01:   lane_b = word[15:8];
      2'b10:   lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    case (ld_size_e'(size))
      SZ_BYTE: result = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SZ_HALF: result = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: IDLE -> BUSY (bus read) -> DONE pulse.
// Optional bus-ack timeout enabled by defining LOAD_UNIT_TIMEOUT_EN.
module load_unit
  import otter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ld_start,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic [31:0] DOUT2,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  ld_state_e   state_q, state_d;
  logic [31:0] addr_q;
  ld_size_e    size_q;
  logic        uns_q;
  logic        err_q;
  logic [31:0] dout_q;
  logic [31:0] align_out;
  logic        go_busy, go_err, ack_ok, to_err, to_hit;

  load_align u_align (
    .word        (bus_rdata),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (align_out)
  );

`ifdef LOAD_UNIT_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  assign to_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Count consecutive BUSY cycles; cleared whenever BUSY is left.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                         cnt_q <= '0;
    else if (state_q == LD_BUSY && state_d == LD_BUSY)  cnt_q <= cnt_q + 1'b1;
    else                                                cnt_q <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // Next-state decode; bad size/alignment skips the bus and reports an error.
  always_comb begin
    state_d = state_q;
    go_busy = 1'b0;
    go_err  = 1'b0;
    ack_ok  = 1'b0;
    to_err  = 1'b0;
    case (state_q)
      LD_IDLE: if (ld_start) begin
        if (ld_legal(ld_size_e'(ld_size), ld_addr[1:0])) begin
          go_busy = 1'b1;
          state_d = LD_BUSY;
        end else begin
          go_err  = 1'b1;
          state_d = LD_DONE;
        end
      end
      LD_BUSY: if (bus_ack) begin
        ack_ok  = 1'b1;
        state_d = LD_DONE;
      end else if (to_hit) begin
        to_err  = 1'b1;
        state_d = LD_DONE;
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  // State, captured request, error flag and result register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (go_busy) begin
        addr_q <= ld_addr;
        size_q <= ld_size_e'(ld_size);
        uns_q  <= ld_unsigned;
        err_q  <= 1'b0;
      end
      if (go_err || to_err) err_q  <= 1'b1;
      if (ack_ok)           dout_q <= align_out;
    end
  end

  assign ld_busy  = (state_q != LD_IDLE);
  assign ld_done  = (state_q == LD_DONE);
  assign ld_err   = (state_q == LD_DONE) & err_q;
  assign bus_rd   = (state_q == LD_BUSY);
  assign bus_addr = {addr_q[31:2], 2'b00};
  assign DOUT2    = dout_q;

endmodule
